// File: rtl/output_port_allocator.sv
// Switch allocator and credit controller for one router output link: round-robin
// arbitration over the input buffers, wormhole locking, downstream credit tracking.
module output_port_allocator #(
    parameter int N_IN      = 5,
    parameter int FLIT_W    = 20,
    parameter int BUF_DEPTH = 4,
    parameter int CRED_W    = 3
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic [N_IN*FLIT_W-1:0]   in_flit,
    input  logic [N_IN-1:0]          in_valid,
    input  logic                     ci,
    output logic [N_IN-1:0]          grant,
    output logic [FLIT_W-1:0]        o,
    output logic                     vo,
    output logic                     locked,
    output logic                     err
);
    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    localparam logic [1:0] T_HEAD   = 2'b10;
    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_TAIL   = 2'b01;
    localparam logic [1:0] T_SINGLE = 2'b11;

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    rr_last_q, rr_last_d;
    logic [CRED_W-1:0]   credit_q, credit_d;
    logic [FLIT_W-1:0]   o_q, o_d;
    logic                vo_q, vo_d;
    logic                err_q, err_d;

    logic [N_IN-1:0]     elig_s;
    logic                bad_idle_s;
    logic                found_s;
    logic [IDX_W-1:0]    win_s;
    logic                send_s;
    logic [FLIT_W-1:0]   win_flit_s;
    logic [1:0]          win_type_s;

    // Eligibility, round-robin winner search and next-state computation.
    always_comb begin
        int idx;
        elig_s     = '0;
        bad_idle_s = 1'b0;
        found_s    = 1'b0;
        win_s      = '0;
        idx        = 0;
        for (int k = 0; k < N_IN; k++) begin
            if (state_q == ST_LOCKED) begin
                elig_s[k] = in_valid[k] && (owner_q == IDX_W'(k));
            end else begin
                elig_s[k] = in_valid[k] && in_flit[k*FLIT_W + FLIT_W - 1];
                if (in_valid[k] && !in_flit[k*FLIT_W + FLIT_W - 1]) begin
                    bad_idle_s = 1'b1;
                end else begin
                    bad_idle_s = bad_idle_s;
                end
            end
        end
        // Scan starts just after the last winner so every port gets a turn.
        for (int i = 0; i < N_IN; i++) begin
            idx = int'(rr_last_q) + 1 + i;
            if (idx >= N_IN) begin
                idx = idx - N_IN;
            end else begin
                idx = idx;
            end
            if (!found_s && elig_s[IDX_W'(idx)]) begin
                found_s = 1'b1;
                win_s   = IDX_W'(idx);
            end else begin
                found_s = found_s;
            end
        end

        send_s     = found_s && (credit_q != '0) && !RST;
        win_flit_s = in_flit[win_s*FLIT_W +: FLIT_W];
        win_type_s = win_flit_s[FLIT_W-1 -: 2];
        grant      = send_s ? (N_IN'(1) << win_s) : '0;

        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        if (send_s) begin
            case (win_type_s)
                T_HEAD: begin
                    state_d   = ST_LOCKED;
                    owner_d   = win_s;
                    rr_last_d = win_s;
                end
                T_SINGLE: begin
                    state_d   = ST_IDLE;
                    rr_last_d = win_s;
                end
                T_TAIL:   state_d = ST_IDLE;
                T_BODY:   state_d = state_q;
                default:  state_d = state_q;
            endcase
        end else begin
            state_d = state_q;
        end

        if (send_s && !ci) begin
            credit_d = credit_q - CRED_W'(1);
        end else if (!send_s && ci && (credit_q != CRED_W'(BUF_DEPTH))) begin
            credit_d = credit_q + CRED_W'(1);
        end else begin
            credit_d = credit_q;
        end

        o_d   = send_s ? win_flit_s : o_q;
        vo_d  = send_s;
        err_d = err_q || bad_idle_s
                || ((state_q == ST_LOCKED) && send_s && win_type_s[1])
                || (ci && (credit_q == CRED_W'(BUF_DEPTH)));
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            rr_last_q <= IDX_W'(N_IN - 1);
            credit_q  <= CRED_W'(BUF_DEPTH);
            o_q       <= '0;
            vo_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            credit_q  <= credit_d;
            o_q       <= o_d;
            vo_q      <= vo_d;
            err_q     <= err_d;
        end
    end

    assign o      = o_q;
    assign vo     = vo_q;
    assign locked = (state_q == ST_LOCKED);
    assign err    = err_q;

endmodule
